// File: rtl/boolean_lut_pkg.sv
// Shared sizing helpers and named truth-table constants for the Boolean LUT evaluator.
package boolean_lut_pkg;

  // Truth-table width for an n_in-variable function.
  function automatic int tt_w(input int n_in);
    return 1 << n_in;
  endfunction

  // Table-select width: at least one bit, even when there is a single table.
  function automatic int sel_w(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

  localparam int N_IN_DEFAULT  = 4;
  localparam int N_OUT_DEFAULT = 5;
  localparam int SEL_W_DEFAULT = sel_w(N_OUT_DEFAULT);

  // Index bit 3 is variable a, bit 2 is b, bit 1 is c.
  localparam logic [15:0] TT_XOR_AB  = 16'h0FF0;
  localparam logic [15:0] TT_MAJ_ABC = 16'hFCC0;

endpackage

// File: rtl/boolean_lut_cell.sv
// One output's truth-table register plus its combinational index mux.
module boolean_lut_cell
  import boolean_lut_pkg::*;
#(
  parameter  int N_IN = 4,
  localparam int TT_W = tt_w(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [TT_W-1:0] i_tt,
  input  logic [N_IN-1:0] i_idx,
  output logic            o_y
);

  logic [TT_W-1:0] r_tt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tt <= '0;
    end else if (i_we) begin
      r_tt <= i_tt;
    end
  end

  // TT_W == 2**N_IN, so every index value selects a real table bit.
  assign o_y = r_tt[i_idx];

endmodule

// File: rtl/boolean_lut_eval.sv
// Pipelined programmable N_IN-input / N_OUT-output Boolean evaluator with valid/ready on both sides.
// Define BOOL_LUT_EVAL_CNT_EN to add the 16-bit eval_cnt output-transfer counter port.
module boolean_lut_eval
  import boolean_lut_pkg::*;
#(
  parameter  int N_IN  = N_IN_DEFAULT,
  parameter  int N_OUT = N_OUT_DEFAULT,
  localparam int TT_W  = tt_w(N_IN),
  localparam int SEL_W = sel_w(N_OUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vars,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_y,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [TT_W-1:0]  cfg_tt
`ifdef BOOL_LUT_EVAL_CNT_EN
  ,
  output logic [15:0]      eval_cnt
`endif
);

  logic             w_in_fire;
  logic             w_out_fire;
  logic [N_OUT-1:0] w_we;
  logic [N_OUT-1:0] w_y;
  logic             r_valid;
  logic [N_OUT-1:0] r_y;

  // A config write blocks input so each result sees exactly one table generation.
  assign in_ready   = !cfg_we && (!r_valid || out_ready);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_valid && out_ready;

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_cell
      // Out-of-range cfg_sel values match no cell and are silently dropped.
      assign w_we[gi] = cfg_we && (cfg_sel == SEL_W'(gi));

      boolean_lut_cell #(
        .N_IN (N_IN)
      ) u_cell (
        .clk   (clk),
        .rst   (rst),
        .i_we  (w_we[gi]),
        .i_tt  (cfg_tt),
        .i_idx (in_vars),
        .o_y   (w_y[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_y     <= '0;
    end else if (w_in_fire) begin
      r_valid <= 1'b1;
      r_y     <= w_y;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_y     = r_y;

`ifdef BOOL_LUT_EVAL_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_out_fire) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign eval_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_boolean_lut_eval.sv
// Self-checking bench for boolean_lut_eval (N_IN=4, N_OUT=5): vector table, scoreboard and corner sequences.
module tb_boolean_lut_eval;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_vars;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_y;
  logic        cfg_we;
  logic [2:0]  cfg_sel;
  logic [15:0] cfg_tt;
`ifdef BOOL_LUT_EVAL_CNT_EN
  logic [15:0] eval_cnt;
`endif

  boolean_lut_eval #(.N_IN(4), .N_OUT(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vars   (in_vars),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_tt    (cfg_tt)
`ifdef BOOL_LUT_EVAL_CNT_EN
    ,
    .eval_cnt  (eval_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state, advanced once per cycle by the monitor.
  logic [15:0] m_tt [5];
  logic        m_valid = 1'b0;
  logic [4:0]  m_y     = '0;
  logic [15:0] m_cnt   = '0;
  logic [4:0]  exp_q [$];
  int          n_out_fire = 0;
  bit          mon_en = 0;

  function automatic logic [4:0] model_y(input logic [3:0] v);
    logic [4:0] r;
    for (int k = 0; k < 5; k++) r[k] = m_tt[k][v];
    return r;
  endfunction

  initial begin
    logic       rdy;
    logic [4:0] e;
    for (int k = 0; k < 5; k++) m_tt[k] = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("mon_out_valid", out_valid, m_valid);
        check("mon_out_y", out_y, m_y);
        rdy = !cfg_we && (!m_valid || out_ready);
        check("mon_in_ready", in_ready, rdy);
`ifdef BOOL_LUT_EVAL_CNT_EN
        check("mon_eval_cnt", eval_cnt, m_cnt);
`endif
        if (rst) begin
          m_valid = 1'b0;
          m_y     = '0;
          m_cnt   = '0;
          exp_q.delete();
          for (int k = 0; k < 5; k++) m_tt[k] = '0;
        end else begin
          if (m_valid && out_ready) begin
            n_out_fire++;
            m_cnt = m_cnt + 16'd1;
            if (exp_q.size() == 0) begin
              check("sb_underflow", 32'd0, 32'd1);
            end else begin
              check("sb_order", out_y, exp_q.pop_front());
            end
          end
          if (in_valid && rdy) begin
            e = model_y(in_vars);
            exp_q.push_back(e);
            m_y     = e;
            m_valid = 1'b1;
          end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
          end
          if (cfg_we && int'(cfg_sel) < 5) m_tt[int'(cfg_sel)] = cfg_tt;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [15:0] tt);
    cfg_we  = 1'b1;
    cfg_sel = sel;
    cfg_tt  = tt;
    tick();
    cfg_we  = 1'b0;
  endtask

  // Offer one vector and hold it until accepted, within a cycle budget.
  task automatic send(input logic [3:0] v);
    logic acc;
    int   guard;
    in_valid = 1'b1;
    in_vars  = v;
    acc      = 1'b0;
    guard    = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      guard++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0] vars;
    logic [4:0] exp_y;
    string      name;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #3000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         idx;
    int         cyc;
    int         o0;
    logic       acc;
`ifdef BOOL_LUT_EVAL_CNT_EN
    logic [15:0] c0;
    int          guard;
`endif

    // Table 0 = XOR(b3,b2), table 2 = MAJ(b3,b2,b1), others zero.
    vecs[0] = '{4'b1000, 5'b00001, "v1000"};
    vecs[1] = '{4'b0110, 5'b00101, "v0110"};
    vecs[2] = '{4'b0000, 5'b00000, "v0000"};
    vecs[3] = '{4'b1111, 5'b00100, "v1111"};
    vecs[4] = '{4'b0100, 5'b00001, "v0100"};
    vecs[5] = '{4'b1100, 5'b00100, "v1100"};
    vecs[6] = '{4'b0011, 5'b00000, "v0011"};
    vecs[7] = '{4'b1010, 5'b00101, "v1010"};

    rst = 1'b1; in_valid = 1'b0; in_vars = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_sel = '0; cfg_tt = '0;

    // Test 1: reset for two cycles, then offer 4'hF.
    tick();
    mon_en = 1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    tick();
    rst = 1'b0; in_valid = 1'b1; in_vars = 4'hF;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_y", out_y, 5'b0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("first_result_valid", out_valid, 1'b1);
    check("first_result_zero", out_y, 5'b0);
    tick();

    // Test 2: load tables and walk the vector table.
    cfg_write(3'd0, 16'h0FF0);
    cfg_write(3'd2, 16'hFCC0);
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].vars);
      @(negedge clk);
      check({"tbl_valid_", vecs[i].name}, out_valid, 1'b1);
      check({"tbl_y_", vecs[i].name}, out_y, vecs[i].exp_y);
      tick();
    end

    // Test 3a: stream 0..15 with a 3-cycle consumer stall.
`ifdef BOOL_LUT_EVAL_CNT_EN
    c0 = eval_cnt;
`endif
    o0 = n_out_fire;
    idx = 0; cyc = 0;
    in_valid = 1'b1; in_vars = 4'h0;
    while (idx < 16 && cyc < 200) begin
      @(negedge clk);
      acc = in_ready;
      if (!out_ready) check("stall_in_ready", in_ready, 1'b0);
      tick();
      cyc++;
      if (acc) begin
        idx++;
        in_vars = 4'(idx);
      end
      out_ready = !(cyc >= 6 && cyc < 9);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("bp_all_accepted", idx, 16);
    check("bp_result_count", n_out_fire - o0, 16);
    check("bp_queue_empty", exp_q.size(), 0);
`ifdef BOOL_LUT_EVAL_CNT_EN
    check("cnt_after_stream", eval_cnt - c0, 16'd16);
`endif

    // Test 3b: full throughput, 16 vectors in 16 cycles.
    o0 = n_out_fire;
    idx = 0; cyc = 0;
    in_valid = 1'b1; in_vars = 4'h0;
    while (idx < 16 && cyc < 100) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      cyc++;
      if (acc) begin
        idx++;
        in_vars = 4'(idx);
      end
    end
    in_valid = 1'b0;
    check("tput_cycles", cyc, 16);
    tick();
    check("tput_results", n_out_fire - o0, 16);

    // Test 4: cfg write collides with an offered vector.
    cfg_we = 1'b1; cfg_sel = 3'd1; cfg_tt = 16'hFF00;
    in_valid = 1'b1; in_vars = 4'b1000;
    @(negedge clk);
    check("cfg_blocks_in_ready", in_ready, 1'b0);
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    check("cfg_release_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("new_table_used", out_y, 5'b00011);
    tick();

    // Test 5: out-of-range selects are ignored.
    cfg_write(3'd5, 16'hFFFF);
    cfg_write(3'd7, 16'hFFFF);
    @(negedge clk);
    check("oor_out_y_held", out_y, 5'b00011);
    tick();
    send(4'b0000);
    @(negedge clk);
    check("oor_tables_v0000", out_y, 5'b00000);
    tick();
    send(4'b1111);
    @(negedge clk);
    check("oor_tables_v1111", out_y, 5'b00110);
    tick();

    // Test 6: reset with a stalled result and a colliding cfg write.
    out_ready = 1'b0;
    send(4'b1000);
    @(negedge clk);
    check("pre_rst_held_valid", out_valid, 1'b1);
    tick();
    rst = 1'b1; cfg_we = 1'b1; cfg_sel = 3'd0; cfg_tt = 16'hFFFF;
    tick();
    rst = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst_clears_valid", out_valid, 1'b0);
    check("rst_clears_y", out_y, 5'b0);
`ifdef BOOL_LUT_EVAL_CNT_EN
    check("rst_clears_cnt", eval_cnt, 16'd0);
`endif
    tick();
    send(4'b1000);
    @(negedge clk);
    check("tables_cleared", out_y, 5'b00000);
    tick();

`ifdef BOOL_LUT_EVAL_CNT_EN
    // Test 7: 65536 transfers wrap the counter to its starting value.
    c0 = eval_cnt;
    o0 = n_out_fire;
    guard = 0;
    in_valid = 1'b1; in_vars = 4'h3;
    while ((n_out_fire - o0) < 65536 && guard < 70000) begin
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check("wrap_transfers", n_out_fire - o0, 65536);
    check("wrap_eval_cnt", eval_cnt, c0);
    repeat (2) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
